// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  // Canonical no-op (addi x0, x0, 0) that decode inserts on bubbles.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_e;

  // One fetch-queue slot: the instruction and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // The I-cache returns words in memory byte order; reverse them so that
  // bit 0 is the LSB of the opcode.
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: I-cache request/response, execute redirect and decode
// handshake. master is the fetch side, slave is the surrounding pipeline.
interface instr_fetch_if;
  logic        icache_ren_o;
  logic [29:0] icache_addr_o;
  logic [31:0] icache_rdata_i;
  logic        icache_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;

  modport master (
    output icache_ren_o, icache_addr_o, inst_valid_o, inst_o, pc_o,
    input  icache_rdata_i, icache_stall_i, redirect_i, redirect_pc_i,
           inst_ready_i
  );

  modport slave (
    input  icache_ren_o, icache_addr_o, inst_valid_o, inst_o, pc_o,
    output icache_rdata_i, icache_stall_i, redirect_i, redirect_pc_i,
           inst_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of {pc, inst} between fetch and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fq_entry_t                  din_i,
  output fq_entry_t                  head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  // Overflow/underflow requests are silently dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; flush wins over push/pop.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: PC, I-cache issue, redirect handling and the
// fetch queue feeding decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_q;
  logic [29:0]   pc_q;        // word PC of the next request
  logic [29:0]   drop_addr_q; // abandoned request still owed a completion
  logic [29:0]   tgt;
  logic          ren, complete, push, pop;
  logic          q_empty, q_full;
  logic [CW-1:0] q_count;
  fq_entry_t     q_din, q_head;

  assign tgt = 30'((bus.redirect_pc_i & ~32'h3) >> 2);

  // Issue depends on registered state only; rst_n gating keeps the bus
  // quiet while reset is held (the I-cache shares the same reset).
  assign ren      = rst_n && ((state_q == DROP) || !q_full);
  assign complete = ren && !bus.icache_stall_i;
  assign push     = (state_q == RUN) && complete && !bus.redirect_i;
  assign pop      = !q_empty && bus.inst_ready_i && !bus.redirect_i;

  assign q_din = '{pc: {pc_q, 2'b00}, inst: bswap(bus.icache_rdata_i)};

  fetch_queue #(.DEPTH(DEPTH)) u_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_i),
    .din_i   (q_din),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // PC / FSM: a redirect with a request in flight parks its address in
  // DROP until the I-cache finishes it, then its data is thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC[31:2];
      drop_addr_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.redirect_i) begin
            pc_q <= tgt;
            if (ren && bus.icache_stall_i) begin
              state_q     <= DROP;
              drop_addr_q <= pc_q;
            end
          end else if (complete) begin
            pc_q <= pc_q + 30'd1;
          end
        end
        DROP: begin
          if (bus.redirect_i) pc_q <= tgt;
          if (complete) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.icache_ren_o  = ren;
  assign bus.icache_addr_o = !rst_n ? '0 : (state_q == DROP) ? drop_addr_q : pc_q;
  assign bus.inst_valid_o  = !q_empty;
  assign bus.inst_o        = q_head.inst;
  assign bus.pc_o          = q_head.pc;

  logic unused_cnt;
  assign unused_cnt = ^q_count;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hits, backpressure, stall, redirects,
// PC wrap and asynchronous reset.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));
  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.master));

  // Memory image: the word at word address a is addi x1,x0,5 with a added
  // into the immediate field; the cache presents it byte-reversed.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'h0050_0093 + {a[11:0], 20'b0};
  endfunction
  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return 32'h0050_0093 + {pc[13:2], 20'b0};
  endfunction

  logic [31:0] w1, w2;
  always_comb begin
    w1 = mem_word(bus.icache_addr_o);
    w2 = mem_word(bus2.icache_addr_o);
    bus.icache_rdata_i  = {w1[7:0], w1[15:8], w1[23:16], w1[31:24]};
    bus2.icache_rdata_i = {w2[7:0], w2[15:8], w2[23:16], w2[31:24]};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset DUT1, check reset values, release; returns in cycle 1.
  task automatic rst1();
    bus.icache_stall_i = 1'b0;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = '0;
    bus.inst_ready_i   = 1'b1;
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_ren",   32'(bus.icache_ren_o),  0);
    chk("rst_addr",  32'(bus.icache_addr_o), 0);
    chk("rst_valid", 32'(bus.inst_valid_o),  0);
    chk("rst_inst",  bus.inst_o, 0);
    chk("rst_pc",    bus.pc_o,   0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst2_n = 1'b0;
    bus2.icache_stall_i = 1'b0;
    bus2.redirect_i     = 1'b0;
    bus2.redirect_pc_i  = '0;
    bus2.inst_ready_i   = 1'b1;

    // Reset and back-to-back hits
    rst1();
    chk("hit_c1_ren",  32'(bus.icache_ren_o), 1);
    chk("hit_c1_addr", 32'(bus.icache_addr_o), 0);
    chk("hit_c1_vld",  32'(bus.inst_valid_o), 0);
    cyc();
    chk("hit_c2_vld",  32'(bus.inst_valid_o), 1);
    chk("hit_c2_inst", bus.inst_o, 32'h0050_0093);
    chk("hit_c2_pc",   bus.pc_o, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("hit_pc",   bus.pc_o, 32'(4 * i));
      chk("hit_inst", bus.inst_o, exp_inst(32'(4 * i)));
      chk("hit_vld",  32'(bus.inst_valid_o), 1);
    end

    // Backpressure
    rst1();
    bus.inst_ready_i = 1'b0;
    cyc();                                          // cycle 2
    chk("bp_c2_pc", bus.pc_o, 0);
    cyc();                                          // cycle 3: full
    chk("bp_c3_ren", 32'(bus.icache_ren_o), 0);
    chk("bp_c3_pc",  bus.pc_o, 0);
    cyc();                                          // cycle 4
    chk("bp_c4_ren", 32'(bus.icache_ren_o), 0);
    chk("bp_c4_pc",  bus.pc_o, 0);
    bus.inst_ready_i = 1'b1;
    cyc();                                          // cycle 5
    chk("bp_c5_pc",   bus.pc_o, 4);
    chk("bp_c5_ren",  32'(bus.icache_ren_o), 1);
    chk("bp_c5_addr", 32'(bus.icache_addr_o), 2);
    cyc();
    chk("bp_c6_pc",   bus.pc_o, 8);

    // Stalled request at PC 4
    rst1();
    cyc();                                          // cycle 2, addr 1
    bus.icache_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("st_addr", 32'(bus.icache_addr_o), 1);
      chk("st_ren",  32'(bus.icache_ren_o), 1);
      chk("st_vld",  32'(bus.inst_valid_o), 0);
    end
    bus.icache_stall_i = 1'b0;
    chk("st_addr_last", 32'(bus.icache_addr_o), 1);
    cyc();
    chk("st_pc4",  bus.pc_o, 4);
    chk("st_inst", bus.inst_o, exp_inst(4));
    cyc();
    chk("st_pc8",  bus.pc_o, 8);

    // Redirect during a miss at PC 8
    rst1();
    cyc();                                          // cycle 2
    cyc();                                          // cycle 3, addr 2
    chk("rm_c3_addr", 32'(bus.icache_addr_o), 2);
    bus.icache_stall_i = 1'b1;
    bus.inst_ready_i   = 1'b0;
    cyc();                                          // cycle 4
    chk("rm_c4_vld", 32'(bus.inst_valid_o), 1);
    chk("rm_c4_pc",  bus.pc_o, 4);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0100;
    cyc();                                          // cycle 5, DROP
    bus.redirect_i   = 1'b0;
    bus.inst_ready_i = 1'b1;
    chk("rm_c5_vld",  32'(bus.inst_valid_o), 0);
    chk("rm_c5_addr", 32'(bus.icache_addr_o), 2);
    chk("rm_c5_ren",  32'(bus.icache_ren_o), 1);
    cyc();                                          // cycle 6
    chk("rm_c6_addr", 32'(bus.icache_addr_o), 2);
    bus.icache_stall_i = 1'b0;
    cyc();                                          // cycle 7
    chk("rm_c7_vld",  32'(bus.inst_valid_o), 0);
    chk("rm_c7_addr", 32'(bus.icache_addr_o), 32'h40);
    cyc();                                          // cycle 8
    chk("rm_c8_vld",  32'(bus.inst_valid_o), 1);
    chk("rm_c8_pc",   bus.pc_o, 32'h100);
    chk("rm_c8_inst", bus.inst_o, exp_inst(32'h100));

    // Redirect in a completion cycle with decode ready
    rst1();
    cyc();                                          // cycle 2
    chk("rc_c2_pc", bus.pc_o, 0);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0203;
    cyc();                                          // cycle 3
    bus.redirect_i = 1'b0;
    chk("rc_c3_vld",  32'(bus.inst_valid_o), 0);
    chk("rc_c3_ren",  32'(bus.icache_ren_o), 1);
    chk("rc_c3_addr", 32'(bus.icache_addr_o), 32'h80);
    cyc();
    chk("rc_c4_pc",   bus.pc_o, 32'h200);
    chk("rc_c4_inst", bus.inst_o, exp_inst(32'h200));

    // PC wrap and asynchronous reset on the second instance
    cyc();
    rst2_n = 1'b1;
    #1;                                             // cycle 1
    chk("wr_c1_addr", 32'(bus2.icache_addr_o), 32'h3FFF_FFFE);
    cyc();
    chk("wr_pc0", bus2.pc_o, 32'hFFFF_FFF8);
    cyc();
    chk("wr_pc1", bus2.pc_o, 32'hFFFF_FFFC);
    cyc();                                          // cycle 4
    chk("wr_pc2",  bus2.pc_o, 32'h0000_0000);
    chk("wr_inst", bus2.inst_o, exp_inst(0));
    bus2.icache_stall_i = 1'b1;
    bus2.inst_ready_i   = 1'b0;
    cyc();                                          // cycle 5
    chk("wr_c5_vld", 32'(bus2.inst_valid_o), 1);
    chk("wr_c5_ren", 32'(bus2.icache_ren_o), 1);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("ar_ren",   32'(bus2.icache_ren_o), 0);
    chk("ar_vld",   32'(bus2.inst_valid_o), 0);
    chk("ar_addr",  32'(bus2.icache_addr_o), 0);
    chk("ar_pc",    bus2.pc_o, 0);
    chk("ar_inst",  bus2.inst_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
